// File: rtl/uvml_stream_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uvml_stream_arbiter : N-channel buffered valid/ready stream arbiter with
// round-robin / fixed-priority selection and per-channel lock.  Rev 1.0
// ---------------------------------------------------------------------------
module uvml_stream_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int ARB_MODE   = 0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_CH-1:0]                     in_valid,
  output logic [NUM_CH-1:0]                     in_ready,
  input  logic [NUM_CH*DATA_W-1:0]              in_data,
  input  logic [NUM_CH-1:0]                     in_lock,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [DATA_W-1:0]                     out_data,
  output logic [$clog2(NUM_CH)-1:0]             out_ch,
  output logic [NUM_CH*$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [NUM_CH-1:0] nonempty;
  logic [NUM_CH-1:0] eligible;
  logic [NUM_CH-1:0] pop;
  logic [DATA_W-1:0] head [NUM_CH];
  logic              load;
  logic              grant_vld;
  logic              lock_found;
  logic [CH_W-1:0]   grant_ch;
  logic [CH_W-1:0]   rr_ptr;

  assign load = !out_valid || out_ready;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [DATA_W-1:0] mem [FIFO_DEPTH];
      logic [PTR_W-1:0]  wr_ptr;
      logic [PTR_W-1:0]  rd_ptr;
      logic [LVL_W-1:0]  level;
      logic              push;

      // Full is judged on the registered level only, so a pop in the same
      // cycle never lets a push through a full FIFO.
      assign in_ready[i] = !rst && (level != LVL_W'(FIFO_DEPTH));
      assign push        = in_valid[i] && in_ready[i];
      assign nonempty[i] = (level != '0);
      assign head[i]     = mem[rd_ptr];
      assign fifo_level[i*LVL_W +: LVL_W] = level;

      always_ff @(posedge clk) begin
        if (push) begin
          mem[wr_ptr] <= in_data[i*DATA_W +: DATA_W];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          level  <= '0;
        end else begin
          if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
          end
          if (pop[i]) begin
            rd_ptr <= rd_ptr + 1'b1;
          end
          if (push && !pop[i]) begin
            level <= level + 1'b1;
          end else if (!push && pop[i]) begin
            level <= level - 1'b1;
          end
        end
      end
    end
  endgenerate

  always_comb begin
    int idx;
    idx        = 0;
    eligible   = nonempty;
    lock_found = 1'b0;
    // Lowest-index lock request owns the output; others are blocked even
    // while the owner has nothing to send.
    for (int i = 0; i < NUM_CH; i++) begin
      if (in_lock[i] && !lock_found) begin
        lock_found  = 1'b1;
        eligible    = '0;
        eligible[i] = nonempty[i];
      end
    end

    grant_vld = 1'b0;
    grant_ch  = '0;
    for (int off = 0; off < NUM_CH; off++) begin
      idx = (ARB_MODE == 0) ? ((int'(rr_ptr) + off) % NUM_CH) : off;
      if (eligible[idx] && !grant_vld) begin
        grant_vld = 1'b1;
        grant_ch  = CH_W'(idx);
      end
    end

    pop = '0;
    if (load && grant_vld) begin
      pop[grant_ch] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= '0;
    end else if (load) begin
      out_valid <= grant_vld;
      if (grant_vld) begin
        out_data <= head[grant_ch];
        out_ch   <= grant_ch;
        if (ARB_MODE == 0) begin
          rr_ptr <= (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : grant_ch + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uvml_stream_arbiter.sv
`default_nettype none
// Directed self-checking bench: round-robin and fixed-priority instances
// share one stimulus stream; expected beats are hand-derived constants.
module tb_uvml_stream_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   in_valid = '0;
  logic [127:0] in_data = '0;
  logic [3:0]   in_lock = '0;
  logic         out_ready = 1'b0;

  logic [3:0]   rr_in_ready, fp_in_ready;
  logic         rr_out_valid, fp_out_valid;
  logic [31:0]  rr_out_data, fp_out_data;
  logic [1:0]   rr_out_ch, fp_out_ch;
  logic [11:0]  rr_level, fp_level;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  uvml_stream_arbiter #(.NUM_CH(4), .DATA_W(32), .FIFO_DEPTH(4), .ARB_MODE(0)) dut_rr (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rr_in_ready),
    .in_data(in_data), .in_lock(in_lock), .out_valid(rr_out_valid),
    .out_ready(out_ready), .out_data(rr_out_data), .out_ch(rr_out_ch),
    .fifo_level(rr_level)
  );

  uvml_stream_arbiter #(.NUM_CH(4), .DATA_W(32), .FIFO_DEPTH(4), .ARB_MODE(1)) dut_fp (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(fp_in_ready),
    .in_data(in_data), .in_lock(in_lock), .out_valid(fp_out_valid),
    .out_ready(out_ready), .out_data(fp_out_data), .out_ch(fp_out_ch),
    .fifo_level(fp_level)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // v=0 checks only that no beat is presented
  task automatic chk_beat(input string tag, input bit fp, input bit v, input int ch, input int d);
    logic        ov;
    logic [1:0]  oc;
    logic [31:0] od;
    ov = fp ? fp_out_valid : rr_out_valid;
    oc = fp ? fp_out_ch    : rr_out_ch;
    od = fp ? fp_out_data  : rr_out_data;
    if (!v) chk(tag, {63'd0, ov}, 64'd0);
    else    chk(tag, {29'd0, ov, oc, od}, {29'd0, 1'b1, 2'(ch), 32'(d)});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = '0;
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    // Reset / idle
    tick(); tick(); tick();
    chk("in_ready_in_reset", {60'd0, rr_in_ready}, 64'h0);
    rst = 1'b0;
    #1;
    chk("reset_in_ready", {60'd0, rr_in_ready}, 64'hF);
    chk("reset_level", {52'd0, rr_level}, 64'h0);
    chk_beat("reset_out_valid", 0, 0, 0, 0);
    for (int n = 0; n < 10; n++) begin
      tick();
      chk_beat("idle_out_valid", 0, 0, 0, 0);
    end

    // Round-robin fairness: 3 beats per channel, first beat loads early
    for (int k = 0; k < 3; k++) begin
      in_valid = 4'hF;
      for (int c = 0; c < 4; c++) in_data[c*32 +: 32] = (c << 8) | k;
      tick();
    end
    in_valid = '0;
    chk("rr_preload_level", {52'd0, rr_level}, {52'd0, 3'd3, 3'd3, 3'd3, 3'd2});
    chk_beat("rr_beat0", 0, 1, 0, 32'h000);
    out_ready = 1'b1;
    for (int n = 1; n < 12; n++) begin
      tick();
      chk_beat($sformatf("rr_beat%0d", n), 0, 1, n % 4, ((n % 4) << 8) | (n / 4));
    end
    tick();
    chk_beat("rr_drained", 0, 0, 0, 0);

    // Fixed priority with a channel-0 beat inserted mid-stream
    out_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      in_valid = 4'b1010;
      in_data  = '0;
      in_data[1*32 +: 32] = 32'h100 | k;
      in_data[3*32 +: 32] = 32'h300 | k;
      tick();
    end
    in_valid = '0;
    chk_beat("fp_beat0", 1, 1, 1, 32'h100);
    out_ready = 1'b1;
    tick();
    chk_beat("fp_beat1", 1, 1, 1, 32'h101);
    in_valid = 4'b0001;
    in_data[31:0] = 32'h0AA;
    tick();
    in_valid = '0;
    chk_beat("fp_beat2", 1, 1, 3, 32'h300);
    tick();
    chk_beat("fp_ch0_insert", 1, 1, 0, 32'h0AA);
    tick();
    chk_beat("fp_beat4", 1, 1, 3, 32'h301);
    tick();
    chk_beat("fp_drained", 1, 0, 0, 0);

    // Lock on channel 2 while channel 0 waits
    out_ready = 1'b0;
    do_reset();
    in_lock = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      in_valid = 4'b0101;
      in_data  = '0;
      in_data[0*32 +: 32] = 32'h000 | k;
      in_data[2*32 +: 32] = 32'h200 | k;
      tick();
    end
    in_valid = '0;
    chk_beat("lock_beat0", 0, 1, 2, 32'h200);
    out_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      tick();
      chk_beat($sformatf("lock_beat%0d", k), 0, 1, 2, 32'h200 | k);
    end
    tick();
    chk_beat("lock_owner_empty", 0, 0, 0, 0);
    tick();
    chk_beat("lock_still_blocked", 0, 0, 0, 0);
    chk("lock_ch0_level", {61'd0, rr_level[2:0]}, 64'd4);
    in_lock = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_beat($sformatf("unlock_ch0_beat%0d", k), 0, 1, 0, k);
    end
    tick();
    chk_beat("unlock_drained", 0, 0, 0, 0);

    // Full / backpressure on channel 1
    out_ready = 1'b0;
    do_reset();
    in_data = '0;
    for (int k = 0; k < 7; k++) begin
      in_valid = 4'b0010;
      in_data[1*32 +: 32] = 32'h100 | k;
      tick();
      if (k == 4) begin
        chk("full_level_k4", {61'd0, rr_level[5:3]}, 64'd4);
        chk("full_in_ready_k4", {63'd0, rr_in_ready[1]}, 64'd0);
      end
    end
    chk("full_level", {61'd0, rr_level[5:3]}, 64'd4);
    chk("full_in_ready", {63'd0, rr_in_ready[1]}, 64'd0);
    chk_beat("full_out_beat", 0, 1, 1, 32'h100);
    in_data[1*32 +: 32] = 32'h107;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk_beat("bp_pop_one", 0, 1, 1, 32'h101);
    chk("bp_level_after_pop", {61'd0, rr_level[5:3]}, 64'd3);
    chk("bp_in_ready_restored", {63'd0, rr_in_ready[1]}, 64'd1);
    tick();
    in_valid = '0;
    chk("bp_refill_level", {61'd0, rr_level[5:3]}, 64'd4);
    chk("bp_refill_in_ready", {63'd0, rr_in_ready[1]}, 64'd0);

    // Reset while a beat is held and a FIFO is full
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", {60'd0, rr_in_ready}, 64'h0);
    tick();
    chk_beat("midrst_out_valid", 0, 0, 0, 0);
    chk("midrst_level", {52'd0, rr_level}, 64'h0);
    rst = 1'b0;
    #1;
    chk("midrst_in_ready_after", {60'd0, rr_in_ready}, 64'hF);
    out_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      tick();
      chk_beat("midrst_no_stale_rr", 0, 0, 0, 0);
      chk_beat("midrst_no_stale_fp", 1, 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
